// File: rtl/alu_serial_if.sv
// rtl/alu_serial_if.sv - request, slice and result signals of the bit-serial ALU controller
//
// Purpose: groups the request handshake, the 1-bit slice drive/return and the
//          result handshake so the controller and its environment share one bundle.
// Modports:
//   slave  - the controller: takes in_valid/in_a/in_b/in_sel, slice_r/slice_cout,
//            out_ready; drives in_ready, slice_a/slice_b/slice_sel, out_valid,
//            out_r, out_cout.
//   master - the environment (requester, slice and result consumer): the mirror image.
// WIDTH must match the WIDTH of the controller that binds the slave modport.
interface alu_serial_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_sel;
  logic             slice_a;
  logic             slice_b;
  logic [2:0]       slice_sel;
  logic             slice_r;
  logic             slice_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic             out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, slice_r, slice_cout, out_ready,
    output in_ready, slice_a, slice_b, slice_sel, out_valid, out_r, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, slice_r, slice_cout, out_ready,
    input  in_ready, slice_a, slice_b, slice_sel, out_valid, out_r, out_cout
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial controller feeding a 1-bit ALU slice, LSB first
//
// Purpose: accepts one WIDTH-bit request, walks the operands through an external
//          combinational 1-bit slice one bit per cycle, assembles the result and
//          presents it on a valid/ready handshake.
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - alu_serial_if.slave: in_* request, slice_* drive/return, out_* result
//   op_count  - (only with ALU_SERIAL_OPCNT_EN) 16-bit saturating count of
//               completed result handshakes
// Build option: define ALU_SERIAL_OPCNT_EN to add the op_count output and counter.
module alu_serial_ctrl #(
  parameter int WIDTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_serial_if.slave bus
`ifdef ALU_SERIAL_OPCNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       sel_q;
  logic [WIDTH-1:0] out_r_q;
  logic             out_cout_q;
  logic             out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      out_r_q     <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            sel_q <= bus.in_sel;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          out_r_q[idx] <= bus.slice_r;
          if (idx == LAST_IDX) begin
            out_cout_q <= bus.slice_cout;
            idx        <= '0;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // out_valid rises one cycle after DONE entry, so the last captured bit
          // has been in out_r for a full cycle before the result is offered.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.slice_a   = (state == RUN) ? a_q[idx] : 1'b0;
  assign bus.slice_b   = (state == RUN) ? b_q[idx] : 1'b0;
  assign bus.slice_sel = (state == RUN) ? sel_q : 3'b000;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_cout  = out_cout_q;

`ifdef ALU_SERIAL_OPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (state == DONE && out_valid_q && bus.out_ready && op_count != 16'hFFFF) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - self-checking bench for alu_serial_ctrl
module tb_alu_serial_ctrl;
  localparam int W = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_serial_if #(.WIDTH(W)) bif ();

`ifdef ALU_SERIAL_OPCNT_EN
  logic [15:0] op_count;
`endif

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
`ifdef ALU_SERIAL_OPCNT_EN
    ,
    .op_count (op_count)
`endif
  );

  // Bench slice: 000 AND, 001 OR, 010 XOR, 011/100/110/111 NOT A, 101 pass A with carry = A.
  always_comb begin
    bif.slice_r    = 1'b0;
    bif.slice_cout = 1'b0;
    case (bif.slice_sel)
      3'b000: bif.slice_r = bif.slice_a & bif.slice_b;
      3'b001: bif.slice_r = bif.slice_a | bif.slice_b;
      3'b010: bif.slice_r = bif.slice_a ^ bif.slice_b;
      3'b101: begin
        bif.slice_r    = bif.slice_a;
        bif.slice_cout = bif.slice_a;
      end
      default: bif.slice_r = ~bif.slice_a;
    endcase
  end

  // Whole-word reference of what the serialized slice should assemble.
  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] sel);
    case (sel)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b101:  return a;
      default: return ~a;
    endcase
  endfunction

  function automatic logic ref_c(input logic [W-1:0] a, input logic [2:0] sel);
    return (sel == 3'b101) ? a[W-1] : 1'b0;
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
    end
  endtask

  // One full request: accept, wait for the result (bounded), optionally hold
  // out_ready low for 'hold' cycles, optionally pulse a competing request after
  // 'inj_at' cycles of RUN, then complete the handshake.
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                         input int hold, input int inj_at);
    logic [W-1:0] er;
    logic         ec;
    int           lat;
    logic         busy_ok;
    logic         stable;
    er = ref_r(a, b, sel);
    ec = ref_c(a, sel);
    @(negedge clk);
    chk1("in_ready_idle", bif.in_ready, 1'b1);
    bif.in_valid = 1'b1;
    bif.in_a     = a;
    bif.in_b     = b;
    bif.in_sel   = sel;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    bif.in_a     = ~a;
    bif.in_b     = ~b;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bif.out_valid && lat < 400) begin
      if (lat == inj_at) begin
        bif.in_valid = 1'b1;
        bif.in_sel   = sel ^ 3'b011;
      end else begin
        bif.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (!bif.out_valid && bif.in_ready) busy_ok = 1'b0;
    end
    bif.in_valid = 1'b0;
    chk("latency", W'(lat), W'(W + 1));
    chk1("in_ready_busy", busy_ok, 1'b1);
    chk("out_r", bif.out_r, er);
    chk1("out_cout", bif.out_cout, ec);
    chk1("in_ready_done", bif.in_ready, 1'b0);
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (!bif.out_valid || bif.out_r !== er || bif.out_cout !== ec || bif.in_ready ||
          bif.slice_a || bif.slice_b || bif.slice_sel != 3'b000)
        stable = 1'b0;
    end
    if (hold > 0) chk1("hold_stable", stable, 1'b1);
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    n_hs++;
    chk1("release_out_valid", bif.out_valid, 1'b0);
    chk1("release_in_ready", bif.in_ready, 1'b1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W-1:0] exp_r;
    logic         exp_c;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rs;
    logic [W-1:0] msb_only;
    msb_only = '0;
    msb_only[W-1] = 1'b1;

    vecs[0] = '{{W{1'b1}}, {16{8'hF0}}, 3'b000, {16{8'hF0}}, 1'b0};
    vecs[1] = '{'0, {16{8'hF0}}, 3'b011, {W{1'b1}}, 1'b0};
    vecs[2] = '{msb_only, '0, 3'b101, msb_only, 1'b1};
    vecs[3] = '{{16{8'h5A}}, {16{8'h3C}}, 3'b010, {16{8'h66}}, 1'b0};
    vecs[4] = '{{16{8'h5A}}, {16{8'h3C}}, 3'b001, {16{8'h7E}}, 1'b0};
    vecs[5] = '{{16{8'h5A}}, {16{8'h3C}}, 3'b110, {16{8'hA5}}, 1'b0};
    vecs[6] = '{'0, {W{1'b1}}, 3'b111, {W{1'b1}}, 1'b0};
    vecs[7] = '{{W{1'b1}}, '0, 3'b101, {W{1'b1}}, 1'b1};

    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_a      = {W{1'b1}};
    bif.in_b      = {W{1'b1}};
    bif.in_sel    = 3'b111;
    bif.out_ready = 1'b0;
    #3;
    chk1("rst_out_valid", bif.out_valid, 1'b0);
    chk("rst_out_r", bif.out_r, '0);
    chk1("rst_out_cout", bif.out_cout, 1'b0);
    chk1("rst_in_ready", bif.in_ready, 1'b1);
    chk1("rst_slice_a", bif.slice_a, 1'b0);
    chk("rst_slice_sel", W'(bif.slice_sel), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("in_ready_after_release", bif.in_ready, 1'b1);

    // Table vectors, checked against their hand-written expectations.
    for (int i = 0; i < 8; i++) begin
      chk("table_model_r", ref_r(vecs[i].a, vecs[i].b, vecs[i].sel), vecs[i].exp_r);
      run_req(vecs[i].a, vecs[i].b, vecs[i].sel, (i == 0) ? 10 : 0, -1);
    end

    // Randomized requests against the whole-word model.
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rs = 3'($urandom_range(0, 7));
      run_req(ra, rb, rs, $urandom_range(0, 3), -1);
    end

    // Competing request pulsed at idx 40 must be ignored.
    run_req({16{8'hC3}}, {16{8'h0F}}, 3'b000, 2, 40);

`ifdef ALU_SERIAL_OPCNT_EN
    chk("op_count_before_reset", W'(op_count), W'(n_hs));
`endif

    // Reset in the middle of RUN at idx 64.
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_a     = {W{1'b1}};
    bif.in_b     = {W{1'b1}};
    bif.in_sel   = 3'b011;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    repeat (64) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("abort_out_valid", bif.out_valid, 1'b0);
    chk1("abort_in_ready", bif.in_ready, 1'b1);
    chk("abort_out_r", bif.out_r, '0);
    chk1("abort_slice_a", bif.slice_a, 1'b0);
`ifdef ALU_SERIAL_OPCNT_EN
    chk("op_count_reset", W'(op_count), '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("abort_in_ready_release", bif.in_ready, 1'b1);
    n_hs = 0;
    run_req({16{8'h96}}, {16{8'h69}}, 3'b010, 0, -1);
    run_req({16{8'h12}}, {16{8'h34}}, 3'b001, 1, -1);
    run_req(msb_only, {W{1'b1}}, 3'b101, 0, -1);
`ifdef ALU_SERIAL_OPCNT_EN
    chk("op_count_three", W'(op_count), W'(3));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 128: operand/result width in bits (legal range 2..256).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  controller accepts a request this cycle.
REQ-006 SHALL have ports in_a, in_b  input  WIDTH  operands; in_sel  input  3  slice opcode.
REQ-007 SHALL have ports slice_a, slice_b, slice_sel  output  1,1,3  drive to the downstream 1-bit ALU slice.
REQ-008 SHALL have ports slice_r, slice_cout  input  1,1  combinational slice result and carry-out, same cycle.
REQ-009 SHALL have ports out_valid  output  1, out_ready  input  1  result handshake.
REQ-010 SHALL have ports out_r  output  WIDTH  assembled result; out_cout  output  1  slice_cout from the MSB cycle.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-012 SHALL, in IDLE with in_valid=1, latch in_a, in_b, in_sel, clear bit index to 0, and enter RUN.
REQ-013 SHALL, in RUN, drive slice_a = a[idx], slice_b = b[idx], slice_sel = latched sel, LSB first (idx 0..WIDTH-1).
REQ-014 SHALL, each RUN cycle, capture slice_r into result bit idx and increment idx by 1.
REQ-015 SHALL, on the RUN cycle with idx = WIDTH-1, capture slice_cout into out_cout and enter DONE.
REQ-016 SHALL assert out_valid in DONE only; first out_valid exactly WIDTH+1 cycles after the accepting edge.
REQ-017 SHALL hold out_r and out_cout stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, in DONE with out_ready=1, return to IDLE; no new request accepted in that same cycle.
REQ-019 SHALL ignore in_valid outside IDLE; latched operands SHALL NOT change during RUN/DONE.
REQ-020 SHALL pass in_sel values 110 and 111 to the slice unmodified (no opcode checking).
REQ-021 SHALL drive slice_a, slice_b = 0 and slice_sel = 000 outside RUN.

Reset
REQ-022 SHALL on rst_n=0 immediately force IDLE, idx=0, out_valid=0, out_r=0, out_cout=0, latched operands 0.
REQ-023 SHALL abort any in-flight RUN or DONE on reset; no partial result is ever presented.
REQ-024 SHALL have in_ready=1 on the first clock edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro ALU_SERIAL_OPCNT_EN defined, add output op_count (16 bits) counting completed out_valid&&out_ready handshakes, saturating at 0xFFFF, reset to 0.
REQ-026 SHALL, without ALU_SERIAL_OPCNT_EN, have no op_count port and no counter logic; all other behaviour identical.

Verification (WIDTH=128, bench slice: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100/110/111 R=~A, C_out=A only for sel 101 else 0)
REQ-027 SHALL pass: in_a=all ones, in_b=0x...F0F0 repeating, sel=000 -> out_r=in_b, out_cout=0, out_valid 129 cycles after accept.
REQ-028 SHALL pass: in_a=0, sel=011 -> out_r=all ones; then in_a MSB=1, sel=101 -> out_cout=1.
REQ-029 SHALL pass: out_ready held 0 for 10 cycles in DONE -> out_r/out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-030 SHALL pass: in_valid pulsed with new operands at RUN idx 40 -> ignored, result matches original request.
REQ-031 SHALL pass: rst_n=0 at RUN idx 64 -> out_valid=0, in_ready=1 after release, next request completes correctly.
REQ-032 SHALL pass (ALU_SERIAL_OPCNT_EN): 3 completed requests -> op_count=3; reset -> op_count=0.
